// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register family.
//
// Contents:
//   state_t   - 2-bit stage state. The encoding equals the number of held
//               entries, so a stage can drive its occupancy output straight
//               from the state register.
//   ST_EMPTY  - no entry held
//   ST_ONE    - one entry held (in the main register)
//   ST_TWO    - two entries held (main + skid)
//   PIPE_NOP  - default bubble/NOP payload, sized down by each user
package pipe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_TWO   = 2'd2;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between two pipeline stages around a pipe_skid_reg.
//
// Signals:
//   flush     - synchronous clear of the stage
//   in_valid  - upstream has data
//   in_ready  - stage can accept data (registered)
//   in_data   - upstream payload, WIDTH bits
//   out_valid - out_data holds a valid entry (registered)
//   out_ready - downstream accepts this cycle
//   out_data  - head payload, WIDTH bits (registered)
//   occupancy - number of held entries, 0..2
//
// Modports:
//   master - the environment around the stage (drives flush, upstream
//            payload and downstream ready)
//   slave  - the stage register itself
interface pipe_skid_reg_if #(
  parameter int WIDTH = 8
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output flush,
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  occupancy
  );

  modport slave (
    input  flush,
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output occupancy
  );

endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer. A downstream stall never reaches upstream combinationally: in_ready
// comes straight from a flop, and the skid register absorbs the one word that
// may arrive while that flop catches up. Throughput is one word per cycle with
// one cycle of latency; out_data carries BUBBLE whenever out_valid is low.
//
// Parameters:
//   WIDTH  - payload width in bits
//   BUBBLE - value presented on out_data while no valid entry is held
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset (to EMPTY, both registers BUBBLE)
//   bus - pipe_skid_reg_if.slave handshake bundle (see interface header)
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PIPE_NOP)
) (
  input logic           clk,
  input logic           rst,
  pipe_skid_reg_if.slave bus
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] next_main;
  logic [WIDTH-1:0] skid_reg;
  logic [WIDTH-1:0] next_skid;
  logic             ready_reg;
  logic             valid_reg;
  logic             accept;
  logic             emit;

  assign accept = bus.in_valid & ready_reg;
  assign emit   = valid_reg & bus.out_ready;

  // Next-state and register-enable logic. Registers that are not written
  // in a given case simply hold. Whenever the head leaves without a
  // replacement the main register is reloaded with BUBBLE so out_data needs
  // no output mux. Flush overrides everything: a same-cycle accept is
  // dropped, a same-cycle emit has already been seen by downstream.
  always_comb begin
    next_state = state;
    next_main  = main_reg;
    next_skid  = skid_reg;
    if (bus.flush) begin
      next_state = ST_EMPTY;
      next_main  = BUBBLE;
      next_skid  = BUBBLE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            next_state = ST_ONE;
            next_main  = bus.in_data;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            next_main = bus.in_data;
          end else if (accept) begin
            next_state = ST_TWO;
            next_skid  = bus.in_data;
          end else if (emit) begin
            next_state = ST_EMPTY;
            next_main  = BUBBLE;
          end
        end
        ST_TWO: begin
          if (emit) begin
            next_state = ST_ONE;
            next_main  = skid_reg;
            next_skid  = BUBBLE;
          end
        end
        default: begin
          next_state = ST_EMPTY;
          next_main  = BUBBLE;
          next_skid  = BUBBLE;
        end
      endcase
    end
  end

  // State, data and handshake flops. in_ready and out_valid get their own
  // flops, loaded from the decoded next state, so neither output has any
  // logic between its flop and the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_reg  <= BUBBLE;
      skid_reg  <= BUBBLE;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
    end else begin
      state     <= next_state;
      main_reg  <= next_main;
      skid_reg  <= next_skid;
      ready_reg <= (next_state != ST_TWO);
      valid_reg <= (next_state != ST_EMPTY);
    end
  end

  assign bus.in_ready  = ready_reg;
  assign bus.out_valid = valid_reg;
  assign bus.out_data  = main_reg;
  assign bus.occupancy = state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized bench for pipe_skid_reg. Two instances share the
// clock and reset: an 8-bit stage with the default zero bubble, and a 32-bit
// stage whose bubble is 0x00000013. Inputs are driven 1 time unit after the
// rising edge; outputs are sampled at the same point, away from the edge.
module tb_pipe_skid_reg;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  pipe_skid_reg_if #(.WIDTH(8))  bus8 ();
  pipe_skid_reg_if #(.WIDTH(32)) bus32 ();

  pipe_skid_reg #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  pipe_skid_reg #(.WIDTH(32), .BUBBLE(32'h0000_0013)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted, and reported with tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the 8-bit stage inputs.
  task automatic applyStimulus(input logic fl, input logic iv, input logic [7:0] d,
                               input logic ordy);
    bus8.flush     = fl;
    bus8.in_valid  = iv;
    bus8.in_data   = d;
    bus8.out_ready = ordy;
  endtask

  // Drive the 32-bit stage inputs.
  task automatic applyStimulus32(input logic fl, input logic iv, input logic [31:0] d,
                                 input logic ordy);
    bus32.flush     = fl;
    bus32.in_valid  = iv;
    bus32.in_data   = d;
    bus32.out_ready = ordy;
  endtask

  // Advance one clock and check the bubble invariant on both stages.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!bus8.out_valid)  checkOutput("bubble8", 32'(bus8.out_data), 32'h0);
    if (!bus32.out_valid) checkOutput("bubble32", bus32.out_data, 32'h13);
  endtask

  // Check all four observable outputs of the 8-bit stage.
  task automatic checkStage8(input string tag, input logic v, input logic [7:0] d,
                             input logic r, input logic [1:0] occ);
    checkOutput({tag, ".out_valid"}, 32'(bus8.out_valid), 32'(v));
    checkOutput({tag, ".out_data"},  32'(bus8.out_data),  32'(d));
    checkOutput({tag, ".in_ready"},  32'(bus8.in_ready),  32'(r));
    checkOutput({tag, ".occupancy"}, 32'(bus8.occupancy), 32'(occ));
  endtask

  logic [7:0] model[$];
  logic       rIv;
  logic       rOr;
  logic       rFl;
  logic [7:0] rData;
  logic       mAccept;
  logic       mEmit;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus32(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset state
    tick();
    tick();
    checkStage8("reset", 1'b0, 8'h00, 1'b1, 2'd0);
    checkOutput("reset32.out_data", bus32.out_data, 32'h13);
    rst = 1'b0;
    tick();
    checkStage8("post_reset", 1'b0, 8'h00, 1'b1, 2'd0);

    // Streaming 0x01..0x10 with downstream always ready
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i), 1'b1);
      tick();
      checkStage8("stream", 1'b1, 8'(i), 1'b1, 2'd1);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkStage8("stream_drain", 1'b0, 8'h00, 1'b1, 2'd0);

    // Stall and skid
    applyStimulus(1'b0, 1'b1, 8'hA1, 1'b0);
    tick();
    checkStage8("skid_a1", 1'b1, 8'hA1, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b1, 8'hA2, 1'b0);
    tick();
    checkStage8("skid_full", 1'b1, 8'hA1, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b1, 8'hA3, 1'b0);
    tick();
    checkStage8("skid_hold", 1'b1, 8'hA1, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b1, 8'hA3, 1'b1);
    tick();
    checkStage8("skid_out_a1", 1'b1, 8'hA2, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b1, 8'hA3, 1'b1);
    tick();
    checkStage8("skid_out_a2", 1'b1, 8'hA3, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkStage8("skid_out_a3", 1'b0, 8'h00, 1'b1, 2'd0);

    // Asynchronous reset mid-cycle while holding 0x11/0x22
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
    tick();
    checkStage8("pre_rst_two", 1'b1, 8'h11, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checkStage8("async_rst", 1'b0, 8'h00, 1'b1, 2'd0);
    tick();
    rst = 1'b0;
    tick();
    checkStage8("rst_release", 1'b0, 8'h00, 1'b1, 2'd0);

    // Flush collision in TWO with 0x33/0x44 held and 0x55 offered
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h44, 1'b0);
    tick();
    checkStage8("pre_flush_two", 1'b1, 8'h33, 1'b0, 2'd2);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1);
    tick();
    checkStage8("flush_two", 1'b0, 8'h00, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkStage8("flush_idle1", 1'b0, 8'h00, 1'b1, 2'd0);
    tick();
    checkStage8("flush_idle2", 1'b0, 8'h00, 1'b1, 2'd0);

    // Flush in ONE with a same-cycle accept and emit
    applyStimulus(1'b0, 1'b1, 8'h66, 1'b0);
    tick();
    checkStage8("pre_flush_one", 1'b1, 8'h66, 1'b1, 2'd1);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1);
    tick();
    checkStage8("flush_one", 1'b0, 8'h00, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkStage8("flush_one_idle", 1'b0, 8'h00, 1'b1, 2'd0);

    // 32-bit stage with bubble 0x13: idle, fill, drain
    checkOutput("b32_idle.out_data", bus32.out_data, 32'h13);
    applyStimulus32(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    checkOutput("b32_one.out_data", bus32.out_data, 32'hDEAD_BEEF);
    applyStimulus32(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    tick();
    checkOutput("b32_two.occupancy", 32'(bus32.occupancy), 32'd2);
    applyStimulus32(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("b32_drain1.out_data", bus32.out_data, 32'hCAFE_F00D);
    tick();
    checkOutput("b32_drain2.out_valid", 32'(bus32.out_valid), 32'd0);
    checkOutput("b32_drain2.out_data", bus32.out_data, 32'h13);
    applyStimulus32(1'b0, 1'b0, 32'h0, 1'b0);

    // Random traffic on the 8-bit stage against a queue model
    model.delete();
    for (int c = 0; c < 10000; c++) begin
      rIv   = 1'($urandom_range(0, 1));
      rOr   = 1'($urandom_range(0, 1));
      rFl   = ($urandom_range(0, 31) == 0);
      rData = 8'($urandom_range(0, 255));
      applyStimulus(rFl, rIv, rData, rOr);
      mAccept = rIv && (model.size() < 2);
      mEmit   = rOr && (model.size() > 0);
      tick();
      if (mEmit) void'(model.pop_front());
      if (rFl) model.delete();
      else if (mAccept) model.push_back(rData);
      checkOutput("rand.occupancy", 32'(bus8.occupancy), 32'(model.size()));
      checkOutput("rand.out_valid", 32'(bus8.out_valid), 32'(model.size() > 0));
      checkOutput("rand.in_ready", 32'(bus8.in_ready), 32'(model.size() < 2));
      if (model.size() > 0) checkOutput("rand.out_data", 32'(bus8.out_data), 32'(model[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
